// File: rtl/audio_dac_out_pkg.sv
// -----------------------------------------------------------------------------
// audio_dac_out_pkg
// Shared constants and types for the 1-bit audio DAC output block.
//   SAMPLE_W   : width of a mixed audio sample
//   FRAME_LEN  : cycles per PWM/pop frame (frame counter runs 0..FRAME_LEN-1)
//   FIFO_DEPTH : entries in the sample buffer
//   dac_mode_e : encoding of the SD_MODE parameter of audio_dac_out
// -----------------------------------------------------------------------------
package audio_dac_out_pkg;

   localparam int SAMPLE_W   = 8;
   localparam int FRAME_LEN  = 255;
   localparam int FIFO_DEPTH = 2;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic {
      MODE_PWM = 1'b0,
      MODE_SD  = 1'b1
   } dac_mode_e;

   // Last value of the frame counter; the pop happens in this cycle.
   localparam sample_t FRAME_LAST = sample_t'(FRAME_LEN - 1);

endpackage

// File: rtl/sample_fifo2.sv
// -----------------------------------------------------------------------------
// sample_fifo2
// Two-entry sample FIFO with a registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data this cycle (ignored when full)
//   push_data  : sample to write
//   pop        : remove the head this cycle (ignored when empty)
//   pop_data   : current head entry (valid when count != 0)
//   count      : number of stored entries, 0..2
// Push and pop in the same cycle both take effect; order is preserved.
// -----------------------------------------------------------------------------
module sample_fifo2
   import audio_dac_out_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  sample_t    push_data,
   input  logic       pop,
   output sample_t    pop_data,
   output logic [1:0] count
);

   sample_t mem [FIFO_DEPTH];
   logic    wr_ptr;
   logic    rd_ptr;
   logic    push_ok;
   logic    pop_ok;

   // Guard against over/underflow so the pointers can never desynchronise.
   assign push_ok  = push && (count < 2'(FIFO_DEPTH));
   assign pop_ok   = pop && (count != 2'd0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/audio_dac_out.sv
// -----------------------------------------------------------------------------
// audio_dac_out
// Buffers 8-bit mixed audio samples and drives a 1-bit modulated stream.
//   SD_MODE      : 0 = PWM (duty eff/255), 1 = first-order sigma-delta
//   clk, rst_n   : clock, asynchronous active-low reset
//   sample_in    : unsigned sample 0..255
//   sample_valid : sample_in valid this cycle
//   sample_ready : block can take a sample this cycle
//   mute         : force zero output density while high
//   dac_out      : registered modulated bit stream
//   underrun     : sticky, a frame boundary found the buffer empty
//
// Handshake: a sample transfers on every rising edge where sample_valid and
// sample_ready are both high; sample_ready depends only on the FIFO count,
// never on sample_valid, so the source may hold sample_valid high and wait.
//
// A new level is taken from the FIFO once per 255-cycle frame, in the cycle
// where frame_cnt is 254, so it becomes active exactly at frame_cnt 0.
// -----------------------------------------------------------------------------
module audio_dac_out
   import audio_dac_out_pkg::*;
#(
   parameter int SD_MODE = 0
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   input  logic                mute,
   output logic                dac_out,
   output logic                underrun
);

   sample_t          frame_cnt;
   sample_t          active;
   sample_t          acc;
   sample_t          eff;
   sample_t          fifo_head;
   logic [1:0]       fifo_count;
   logic [SAMPLE_W:0] sd_sum;
   logic             push;
   logic             pop;
   logic             frame_end;
   logic             pwm_bit;

   assign sample_ready = fifo_count < 2'(FIFO_DEPTH);
   assign push         = sample_valid && sample_ready;
   assign frame_end    = frame_cnt == FRAME_LAST;
   assign pop          = frame_end && (fifo_count != 2'd0);

   // Only the registered active level feeds the modulators, so a sample can
   // never reach dac_out in the cycle it is pushed.
   assign eff     = mute ? '0 : active;
   assign pwm_bit = frame_cnt < eff;
   assign sd_sum  = {1'b0, acc} + {1'b0, eff};

   sample_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (sample_in),
      .pop       (pop),
      .pop_data  (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         active    <= '0;
         acc       <= '0;
         dac_out   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         frame_cnt <= frame_end ? '0 : frame_cnt + 8'd1;
         if (pop) begin
            active <= fifo_head;
         end
         acc     <= sd_sum[SAMPLE_W-1:0];
         dac_out <= (SD_MODE == int'(MODE_SD)) ? sd_sum[SAMPLE_W] : pwm_bit;
         // Set has priority over the clear from a push in the same cycle.
         if (frame_end && (fifo_count == 2'd0)) begin
            underrun <= 1'b1;
         end else if (push) begin
            underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_audio_dac_out.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_out
// Two instances (PWM and sigma-delta) share all inputs. Per-frame ones counts
// of the PWM stream are checked by a scoreboard; handshake, flags, mute timing
// and the sigma-delta pattern are checked directly at chosen cycles.
// Cycle e after reset release has frame_cnt = e % 255; the bench tracks e.
// -----------------------------------------------------------------------------
module tb_audio_dac_out;

   logic       clk;
   logic       rst_n;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       mute;
   logic       ready_pwm, ready_sd;
   logic       dac_pwm, dac_sd;
   logic       und_pwm, und_sd;

   int n_cmp  = 0;
   int n_fail = 0;
   int edges  = 0;
   int ones_acc = 0;

   // Entry = {frame index, expected PWM ones in that frame}.
   logic [31:0] exp_q[$];

   audio_dac_out #(.SD_MODE(0)) dut_pwm (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(ready_pwm), .mute(mute), .dac_out(dac_pwm), .underrun(und_pwm)
   );

   audio_dac_out #(.SD_MODE(1)) dut_sd (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(ready_sd), .mute(mute), .dac_out(dac_sd), .underrun(und_sd)
   );

   // ---------------- clock / cycle tracking ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [31:0] ent(input int f, input int o);
      return {16'(f), 16'(o)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edges);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int fr, input int k);
      int tgt;
      tgt = fr * 255 + k;
      if (edges > tgt) begin
         n_cmp++;
         n_fail++;
         $display("FAIL goto: at cycle %0d, expected to reach %0d", edges, tgt);
      end
      while (edges < tgt) tick();
   endtask

   task automatic push_sample(input logic [7:0] v);
      int guard;
      guard = 0;
      while (!ready_pwm && guard < 600) begin
         tick();
         guard++;
      end
      if (!ready_pwm) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push_wait: sample_ready got 0, expected 1 within 600 cycles");
      end
      sample_in    = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   // Sample at cycle e shows the bit computed in cycle e-1, so frame F of the
   // output covers samples e = 255F+1 .. 255F+255.
   initial begin
      logic [31:0] e;
      int idx, fr;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ones_acc = 0;
         end else if (edges >= 1) begin
            idx = (edges - 1) % 255;
            fr  = (edges - 1) / 255;
            if (idx == 0) ones_acc = 0;
            ones_acc += int'(dac_pwm);
            if (idx == 254) begin
               while (exp_q.size() > 0 && int'(exp_q[0][31:16]) < fr) begin
                  e = exp_q.pop_front();
                  n_cmp++;
                  n_fail++;
                  $display("FAIL sb_missed: frame %0d got no compare, expected %0d ones", e[31:16], e[15:0]);
               end
               if (exp_q.size() > 0 && int'(exp_q[0][31:16]) == fr) begin
                  e = exp_q.pop_front();
                  n_cmp++;
                  if (ones_acc != int'(e[15:0])) begin
                     n_fail++;
                     $display("FAIL sb_frame%0d: ones got %0d, expected %0d", fr, ones_acc, e[15:0]);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int ones, last, bad;
      rst_n        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      mute         = 1'b0;

      // Hand-computed PWM ones per frame for the main sequence.
      exp_q.push_back(ent(0, 0));
      exp_q.push_back(ent(1, 128));
      exp_q.push_back(ent(2, 128));
      exp_q.push_back(ent(3, 0));
      exp_q.push_back(ent(4, 255));
      exp_q.push_back(ent(5, 255));
      exp_q.push_back(ent(6, 10));
      exp_q.push_back(ent(7, 20));
      exp_q.push_back(ent(8, 30));
      exp_q.push_back(ent(9, 40));
      exp_q.push_back(ent(10, 40));   // 200 pushed in pop cycle must not bypass
      exp_q.push_back(ent(11, 50));   // 200, muted from frame_cnt 50
      exp_q.push_back(ent(12, 55));   // 150 popped while muted, unmuted at 95
      exp_q.push_back(ent(13, 150));
      exp_q.push_back(ent(14, 64));
      exp_q.push_back(ent(15, 64));

      repeat (3) tick();
      check("rst_dac_pwm", 32'(dac_pwm), 0);
      check("rst_dac_sd", 32'(dac_sd), 0);
      check("rst_underrun", 32'(und_pwm), 0);
      check("rst_ready", 32'(ready_pwm), 1);
      rst_n = 1'b1;
      check("rel_ready", 32'(ready_sd), 1);

      // Push 128 once and hold.
      push_sample(8'd128);
      goto(0, 200);  check("und_before_pop", 32'(und_pwm), 0);
      goto(1, 254);  check("und_after_pop", 32'(und_pwm), 0);
      tick();        check("und_set", 32'(und_pwm), 1);

      // 0 then 255 in consecutive frames; the push also clears underrun.
      push_sample(8'd0);
      check("und_clear", 32'(und_pwm), 0);
      goto(3, 10);
      push_sample(8'd255);

      // Fill with 10, 20, then hold 30 until space opens.
      goto(5, 10);
      push_sample(8'd10);
      push_sample(8'd20);
      sample_in    = 8'd30;
      sample_valid = 1'b1;
      check("full_ready", 32'(ready_pwm), 0);
      goto(5, 254);  check("full_at_pop", 32'(ready_pwm), 0);
      tick();        check("ready_after_pop", 32'(ready_pwm), 1);
      tick();        check("accepted_30", 32'(ready_pwm), 0);
      sample_valid = 1'b0;

      // Push during pop with one entry: count stays 1.
      goto(7, 254);  check("one_entry_ready", 32'(ready_pwm), 1);
      push_sample(8'd40);
      check("push_pop_cnt1", 32'(ready_sd), 1);

      // Push into empty FIFO in the pop cycle: no bypass, set beats clear.
      goto(9, 254);
      push_sample(8'd200);
      check("und_set_wins", 32'(und_pwm), 1);

      // Mute for 300 cycles with active=200, a queued 150 pops meanwhile.
      goto(11, 5);
      push_sample(8'd150);
      check("und_clear2", 32'(und_pwm), 0);
      goto(11, 50);  check("pre_mute", 32'(dac_pwm), 1);
      mute = 1'b1;
      tick();        check("mute_first", 32'(dac_pwm), 0);
      goto(12, 50);  check("mute_mid", 32'(dac_pwm), 0);
      goto(12, 95);
      mute = 1'b0;
      check("mute_last", 32'(dac_pwm), 0);
      tick();        check("unmute", 32'(dac_pwm), 1);

      // Sigma-delta with eff=64: 64 ones in 256 cycles, spaced by 4.
      goto(13, 5);
      push_sample(8'd64);
      goto(14, 2);
      ones = 0;
      last = -1;
      bad  = 0;
      for (int i = 0; i < 256; i++) begin
         if (dac_sd) begin
            ones++;
            if (last >= 0 && i - last != 4) bad++;
            last = i;
         end
         tick();
      end
      check("sd_ones_256", 32'(ones), 64);
      check("sd_bad_gaps", 32'(bad), 0);

      // Reset mid-frame with two samples queued.
      goto(15, 10);
      push_sample(8'd200);
      goto(16, 10);
      push_sample(8'd90);
      push_sample(8'd91);
      goto(16, 100);
      check("pre_reset_dac", 32'(dac_pwm), 1);
      check("pre_reset_full", 32'(ready_pwm), 0);
      rst_n = 1'b0;
      #1;
      check("async_dac_pwm", 32'(dac_pwm), 0);
      check("async_dac_sd", 32'(dac_sd), 0);
      check("async_und", 32'(und_sd), 0);
      check("async_ready", 32'(ready_pwm), 1);
      repeat (3) tick();
      rst_n = 1'b1;
      exp_q.push_back(ent(0, 0));
      exp_q.push_back(ent(1, 0));
      check("rel2_ready", 32'(ready_pwm), 1);
      goto(0, 254);  check("rel2_und_pre", 32'(und_pwm), 0);
      tick();        check("rel2_und_set", 32'(und_pwm), 1);
      goto(2, 2);
      check("sb_drain", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_dac_out.md
AUDIO_DAC_OUT -- requirements
Module: audio_dac_out

Interface
REQ-001 Parameter: SD_MODE, default 0, 0 = PWM modulator, 1 = first-order sigma-delta modulator.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: sample_in  input  8  unsigned mixed audio sample (0..255) from the channel mixer.
REQ-005 Port: sample_valid  input  1  sample_in is valid this cycle.
REQ-006 Port: sample_ready  output  1  block can accept a sample this cycle.
REQ-007 Port: mute  input  1  force zero output density while high.
REQ-008 Port: dac_out  output  1  registered 1-bit modulated stream to the external RC filter/pin.
REQ-009 Port: underrun  output  1  sticky flag: a frame boundary found the buffer empty.

Function
REQ-010 Buffer: 2-entry FIFO; a push occurs when sample_valid && sample_ready.
REQ-011 sample_ready SHALL be high exactly when the FIFO holds fewer than 2 entries; it is combinational from the FIFO count.
REQ-012 Frame counter frame_cnt SHALL count 0..254 and wrap to 0, so each frame is 255 cycles; it runs in both modes.
REQ-013 Pop: in the cycle frame_cnt==254, if the FIFO is non-empty, the head SHALL load into register active and be removed.
REQ-014 Empty at pop: if the FIFO is empty at frame_cnt==254, active SHALL hold its value and underrun SHALL set.
REQ-015 underrun SHALL clear in the cycle after any accepted push; if set and clear coincide, set wins.
REQ-016 Simultaneous push and pop with 1 entry: both SHALL take effect; count stays 1 and FIFO order is preserved.
REQ-017 Push into an empty FIFO during the pop cycle: the new sample SHALL NOT bypass into active in that cycle.
REQ-018 Effective level eff SHALL be 0 when mute=1; otherwise eff = active. Popping continues while muted.
REQ-019 PWM mode (SD_MODE=0): dac_out register SHALL load (frame_cnt < eff) each cycle.
- eff=0: output constantly low.
- eff=255: output constantly high.
- Duty = eff/255.
REQ-020 Sigma-delta mode (SD_MODE=1): 8-bit accumulator acc; each cycle {carry, acc} <= acc + eff (9-bit sum).
- dac_out register SHALL load carry.
- Ones density = eff/256.
REQ-021 Latency: a value in active at cycle t SHALL first affect dac_out at cycle t+1 (one register stage).
REQ-022 mute SHALL take effect on dac_out one cycle after it changes, with no frame alignment.

Reset
REQ-023 While rst_n=0, the following SHALL be 0 asynchronously: frame_cnt, FIFO count and pointers, active, acc, dac_out, underrun.
REQ-024 After reset release, sample_ready SHALL read 1.
REQ-025 Reset asserted mid-frame SHALL discard buffered samples; the first frame after release starts at frame_cnt=0.
REQ-026 Deasserting reset SHALL be synchronised to clk by the block's users; the block requires no internal release sequencing.

Structure
REQ-027 A shared package SHALL hold constants SAMPLE_W=8, FRAME_LEN=255 and FIFO_DEPTH=2, and the mode encoding for SD_MODE.
REQ-028 The FIFO SHALL be a sub-module named sample_fifo2 with push/pop/count ports; the modulators stay in audio_dac_out.
REQ-029 No combinational path SHALL exist from sample_in or sample_valid to dac_out.

Verification
REQ-030 Reset, then PWM mode, push 128 once and hold.
- From the second frame onward, dac_out is high exactly 128 of every 255 cycles.
- underrun stays 0 through the first pop, then sets at the next frame boundary.
REQ-031 PWM mode, push 0 then 255 in consecutive frames.
- Frame n: dac_out all low.
- Frame n+1: all 255 cycles high, with no glitch cycle at the boundary.
REQ-032 Fill FIFO with 10, 20; hold sample_valid with 30.
- sample_ready=0 until the frame_cnt==254 pop.
- 30 is accepted the cycle after the pop.
- active sequence is 10, 20, 30.
REQ-033 SD mode, eff=64.
- Over 256 cycles exactly 64 ones.
- Once acc has cycled, ones are spaced exactly 4 cycles apart.
REQ-034 mute pulse.
- Assert mute for 300 cycles with active=200: dac_out is 0 from one cycle after assertion.
- Queued samples still pop on schedule.
- Output resumes one cycle after deassertion.
REQ-035 Assert rst_n=0 at frame_cnt=100 with 2 samples queued.
- All outputs 0 immediately.
- After release: sample_ready=1 and FIFO empty.
- First pop is at cycle 254 after release and sets underrun.
